serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 5, operand and difference width in bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request; sampled only in IDLE.
REQ-006 a  input  WIDTH  minuend; captured on an accepted start.
REQ-007 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-008 busy  output  1  high while in SHIFT or DONE.
REQ-009 done  output  1  one-cycle pulse when a result is published.
REQ-010 diff  output  WIDTH  (a - b) mod 2^WIDTH, held until the next publish.
REQ-011 borrow_out  output  1  final borrow; 1 when a < b unsigned; held with diff.
REQ-012 hex0  output  8  active-low 7-segment display of diff[3:0]; bit7 = DP; bits 6..0 = g..a.
REQ-013 hex1  output  8  active-low 7-segment display of {2'b00, borrow_out, diff[4]}.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1: capture a and b into shift registers, clear the borrow flop and the bit counter, and go to SHIFT.
REQ-016 SHIFT, each cycle: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br); d shifts into the result register MSB; a and b shift right; the counter increments.
REQ-017 SHIFT SHALL exit to DONE after exactly WIDTH cycles, when counter = WIDTH-1.
REQ-018 DONE: load diff and borrow_out from the result register and borrow flop, assert done for this one cycle, and return to IDLE.
REQ-019 Latency: start sampled at edge N; done is high in the cycle after edge N+WIDTH+1, which is the same cycle diff updates.
REQ-020 start in SHIFT or DONE SHALL be ignored, with no effect on the operation in progress; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-021 Changes on a or b after capture SHALL NOT affect the operation in progress.
REQ-022 diff, borrow_out, hex0 and hex1 SHALL change only in DONE.
REQ-023 hex0 and hex1 SHALL be combinational decodes of the registered diff and borrow_out.
REQ-024 Segment codes, DP off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-025 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap while in SHIFT.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, diff 0, borrow_out 0, and clear all shift, borrow and counter registers.
REQ-027 Reset values of hex0 and hex1 SHALL be C0, the digit 0.
REQ-028 Reset mid-operation SHALL abort the operation: no done pulse, and the old result is lost.
REQ-029 After rst_n deasserts, a start on the first following edge SHALL be accepted.

Structure
REQ-030 Package sub_pkg SHALL hold: the state enum, the default WIDTH, and the 16-entry segment code table.
REQ-031 Sub-module hex_to_seg7 (4-bit in, 8-bit active-low out) SHALL be instantiated twice, for hex0 and hex1.
REQ-032 Datapath, FSM and output registers SHALL reside in serial_subtractor, with no other hierarchy.

Verification
REQ-033 a=9, b=3, start pulse -> busy for 6 cycles; done pulse; diff=6, borrow_out=0, hex0=82, hex1=C0.
REQ-034 a=3, b=9 -> diff=26 (0x1A), borrow_out=1, hex0=88, hex1=B0.
REQ-035 a=31, b=31, then a=0, b=1 -> first result diff=0, borrow_out=0; second result diff=31, borrow_out=1, hex0=8E, hex1=B0.
REQ-036 start held high continuously with a=5, b=2 -> exactly one operation per 7 cycles (IDLE-SHIFTx5-DONE); diff=3; changing a mid-SHIFT has no effect.
REQ-037 rst_n pulsed low 3 cycles after start -> immediate busy=0, diff=0, hex0=C0; no done pulse; a new start then completes normally.
REQ-038 start asserted in the DONE cycle -> ignored; start in the next cycle -> accepted, with done 6 cycles later.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg -- shared definitions for the serial subtractor.
//   state_e    : FSM encoding (IDLE / SHIFT / DONE)
//   DEF_WIDTH  : default operand width
//   SEG_TABLE  : active-low 7-segment codes for 0..F, DP off (bit7 = DP, bits 6..0 = g..a)
//   seg_lookup : nibble -> segment code
package sub_pkg;

   localparam int DEF_WIDTH = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Packed so that SEG_TABLE[n] is the code for digit n; leftmost entry is F.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] seg_lookup(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7 -- combinational hex digit to active-low 7-segment decoder.
//   nibble : 4-bit digit in
//   seg    : 8-bit active-low segments out, bit7 = DP (always off), bits 6..0 = g..a
module hex_to_seg7
   import sub_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   assign seg = seg_lookup(nibble);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial (a - b) mod 2^WIDTH, LSB first, one bit per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled only in IDLE; a/b captured on acceptance
//   busy         : high in SHIFT and DONE
//   done         : one-cycle pulse, coincident with diff/borrow_out updating
//   diff         : registered difference, held until the next publish
//   borrow_out   : registered final borrow (a < b unsigned)
//   hex0, hex1   : active-low 7-seg decodes of diff[3:0] and {2'b00, borrow_out, diff[4]}
// An operation occupies IDLE(accept) -> SHIFT x WIDTH -> DONE -> IDLE.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic [7:0]       hex0,
   output logic [7:0]       hex1
);

   // Counter is $clog2(WIDTH) bits; floor at 1 bit so WIDTH=1 still elaborates.
   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               br_q, br_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               done_q, done_d;

   logic               a0, b0, d_bit;
   logic [WIDTH:0]     res_cat;

   // Full-subtractor on the current LSBs.
   assign a0      = a_sh_q[0];
   assign b0      = b_sh_q[0];
   assign d_bit   = a0 ^ b0 ^ br_q;
   // New bit enters at the MSB; after WIDTH shifts the first bit lands in bit 0.
   assign res_cat = {d_bit, res_q};

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               res_d   = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_d  = res_cat[WIDTH:1];
            br_d   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            // Hold the counter on the last bit so it never wraps inside SHIFT.
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            diff_d   = res_q;
            borrow_d = br_q;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
      end
   end

   assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;

   // Low five bits of diff, zero-extended when WIDTH < 5, for the displays.
   logic [4:0] diff_lo;
   logic [3:0] nib1;

   assign diff_lo = 5'(diff_q);
   assign nib1    = {2'b00, borrow_q, diff_lo[4]};

   hex_to_seg7 u_seg0 (
      .nibble (diff_lo[3:0]),
      .seg    (hex0)
   );

   hex_to_seg7 u_seg1 (
      .nibble (nib1),
      .seg    (hex1)
   );

endmodule
